// File: rtl/gfx128_text_plot_if.sv
// gfx128_text_plot_if: 128-bit framebuffer write port.
// master issues coalesced word writes, slave acknowledges.
interface gfx128_text_plot_if;
  logic         write_request_o;
  logic         write_ack_i;
  logic [31:0]  write_adr_o;
  logic [15:0]  write_sel_o;
  logic [127:0] write_dat_o;

  modport master (
    output write_request_o,
    output write_adr_o,
    output write_sel_o,
    output write_dat_o,
    input  write_ack_i
  );

  modport slave (
    input  write_request_o,
    input  write_adr_o,
    input  write_sel_o,
    input  write_dat_o,
    output write_ack_i
  );
endinterface

// File: rtl/gfx128_text_plot.sv
// gfx128_text_plot: clips glyph pixels, coalesces 8 px per 128-bit word.
// Optional opaque text: define GFX128_TEXT_BKGND_EN.
module gfx128_text_plot #(
  parameter int point_width = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   pix_stb_i,
  input  logic                   pix_set_i,
  input  logic [point_width-1:0] pix_x_i,
  input  logic [point_width-1:0] pix_y_i,
  output logic                   clip_ack_o,
  input  logic                   flush_i,
  input  logic [point_width-1:0] clip_x0_i,
  input  logic [point_width-1:0] clip_y0_i,
  input  logic [point_width-1:0] clip_x1_i,
  input  logic [point_width-1:0] clip_y1_i,
  input  logic [31:0]            target_base_i,
  input  logic [15:0]            pitch_i,
  input  logic [15:0]            fg_color_i,
  input  logic [15:0]            bg_color_i,
  gfx128_text_plot_if.master     wr
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CALC,
    ST_MERGE,
    ST_WRITE,
    ST_ACK
  } state_t;

  state_t state_q, state_d;

  logic [point_width-1:0] px_q, py_q;
  logic                   pset_q;
  logic [31:0]            adr_q;
  logic [2:0]             lane_q;
  logic                   clip_q;
  logic                   buf_vld_q;
  logic [31:0]            buf_adr_q;
  logic [15:0]            buf_sel_q;
  logic [127:0]           buf_dat_q;
  logic                   flush_pend_q;
  logic                   wr_flush_q;
  logic                   wr_req;

  logic [31:0] pix_ofs;
  logic [31:0] lin_adr;
  logic        clip;
  logic        skip;
  logic [15:0] color;
  logic        unused_bits;

  assign pix_ofs = 32'(py_q) * 32'(pitch_i) + 32'(px_q);
  assign lin_adr = {target_base_i[31:4], 4'h0} + (pix_ofs << 1);

  assign clip = (px_q < clip_x0_i) | (px_q >= clip_x1_i) |
                (py_q < clip_y0_i) | (py_q >= clip_y1_i);

`ifdef GFX128_TEXT_BKGND_EN
  assign skip  = clip_q;
  assign color = pset_q ? fg_color_i : bg_color_i;
  assign unused_bits = ^{target_base_i[3:0], lin_adr[0]};
`else
  assign skip  = clip_q | ~pset_q;
  assign color = fg_color_i;
  assign unused_bits = ^{target_base_i[3:0], lin_adr[0], bg_color_i};
`endif

  // state register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next state and handshake outputs
  always_comb begin
    state_d    = state_q;
    clip_ack_o = 1'b0;
    wr_req     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pix_stb_i)
          state_d = ST_CALC;
        else if ((flush_i | flush_pend_q) & buf_vld_q)
          state_d = ST_WRITE;
      end
      ST_CALC:  state_d = ST_MERGE;
      ST_MERGE: begin
        if (skip)
          state_d = ST_ACK;
        else if (buf_vld_q && buf_adr_q != adr_q)
          state_d = ST_WRITE;
        else
          state_d = ST_ACK;
      end
      ST_WRITE: begin
        wr_req = 1'b1;
        if (wr.write_ack_i)
          state_d = wr_flush_q ? ST_IDLE : ST_MERGE;
      end
      ST_ACK: begin
        clip_ack_o = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // pixel capture, address calc, word buffer and flush bookkeeping
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      px_q         <= '0;
      py_q         <= '0;
      pset_q       <= 1'b0;
      adr_q        <= '0;
      lane_q       <= '0;
      clip_q       <= 1'b0;
      buf_vld_q    <= 1'b0;
      buf_adr_q    <= '0;
      buf_sel_q    <= '0;
      buf_dat_q    <= '0;
      flush_pend_q <= 1'b0;
      wr_flush_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (pix_stb_i) begin
          px_q         <= pix_x_i;
          py_q         <= pix_y_i;
          pset_q       <= pix_set_i;
          flush_pend_q <= flush_pend_q | flush_i;
        end else begin
          flush_pend_q <= 1'b0;
        end
      end else if (flush_i) begin
        flush_pend_q <= 1'b1;
      end
      if (state_q == ST_CALC) begin
        adr_q  <= {lin_adr[31:4], 4'h0};
        lane_q <= lin_adr[3:1];
        clip_q <= clip;
      end
      if (state_q != ST_WRITE && state_d == ST_WRITE)
        wr_flush_q <= (state_q == ST_IDLE);
      if (state_q == ST_MERGE && state_d == ST_ACK && !skip) begin
        buf_dat_q[{lane_q, 4'h0} +: 16] <= color;
        buf_sel_q <= buf_sel_q | (16'h3 << {lane_q, 1'b0});
        buf_adr_q <= adr_q;
        buf_vld_q <= 1'b1;
      end
      if (state_q == ST_WRITE && wr.write_ack_i) begin
        buf_vld_q <= 1'b0;
        buf_sel_q <= '0;
        buf_dat_q <= '0;
      end
    end
  end

  assign wr.write_request_o = wr_req;
  assign wr.write_adr_o     = wr_req ? buf_adr_q : 32'h0;
  assign wr.write_sel_o     = wr_req ? buf_sel_q : 16'h0;
  assign wr.write_dat_o     = wr_req ? buf_dat_q : 128'h0;

endmodule

// File: tb/tb_gfx128_text_plot.sv
// tb_gfx128_text_plot: directed vectors plus multi-cycle sequences.
// Acknowledging memory slave logs every accepted write.
module tb_gfx128_text_plot;

`ifdef GFX128_TEXT_BKGND_EN
  localparam bit BK = 1'b1;
`else
  localparam bit BK = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        pix_stb_i = 1'b0;
  logic        pix_set_i = 1'b0;
  logic [15:0] pix_x_i = '0;
  logic [15:0] pix_y_i = '0;
  logic        clip_ack_o;
  logic        flush_i = 1'b0;
  logic [15:0] clip_x0_i = '0;
  logic [15:0] clip_y0_i = '0;
  logic [15:0] clip_x1_i = 16'd640;
  logic [15:0] clip_y1_i = 16'd480;
  logic [31:0] target_base_i = 32'h1000;
  logic [15:0] pitch_i = 16'd640;
  logic [15:0] fg_color_i = 16'hF800;
  logic [15:0] bg_color_i = 16'h001F;

  gfx128_text_plot_if wr ();

  gfx128_text_plot #(.point_width(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pix_stb_i(pix_stb_i), .pix_set_i(pix_set_i),
    .pix_x_i(pix_x_i), .pix_y_i(pix_y_i),
    .clip_ack_o(clip_ack_o), .flush_i(flush_i),
    .clip_x0_i(clip_x0_i), .clip_y0_i(clip_y0_i),
    .clip_x1_i(clip_x1_i), .clip_y1_i(clip_y1_i),
    .target_base_i(target_base_i), .pitch_i(pitch_i),
    .fg_color_i(fg_color_i), .bg_color_i(bg_color_i),
    .wr(wr)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] adr;
    logic [15:0] sel;
    logic [127:0] dat;
  } wr_t;

  typedef struct {
    string       name;
    int          x0, y0, x1, y1;
    logic [31:0] base;
    int          x, y;
    bit          s;
    bit          exp_wr;
    logic [31:0] adr;
    logic [15:0] sel;
    int          lane;
    logic [15:0] col;
  } vec_t;

  wr_t  wq[$];
  int   checks = 0;
  int   errors = 0;
  int   ack_cnt = 0;
  bit   auto_ack = 1'b1;
  bit   man_ack = 1'b0;

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic chk_write(input string n, input logic [31:0] adr,
                           input logic [15:0] sel,
                           input logic [127:0] dat);
    wr_t w;
    if (wq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no write expected adr %h", n, adr);
    end else begin
      w = wq.pop_front();
      chk({n, "_adr"}, 128'(w.adr), 128'(adr));
      chk({n, "_sel"}, 128'(w.sel), 128'(sel));
      chk({n, "_dat"}, w.dat, dat);
    end
  endtask

  // memory slave: immediate ack in auto mode, bench-driven otherwise
  initial begin
    wr.write_ack_i = 1'b0;
    forever begin
      @(posedge clk_i);
      #2;
      if (!auto_ack) begin
        wr.write_ack_i = man_ack;
      end else if (wr.write_ack_i) begin
        wr.write_ack_i = 1'b0;
      end else if (wr.write_request_o) begin
        wq.push_back('{wr.write_adr_o, wr.write_sel_o, wr.write_dat_o});
        wr.write_ack_i = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (clip_ack_o) ack_cnt++;
    end
  end

  task automatic plot(input int x, input int y, input bit s,
                      input bit fl, output int lat,
                      output int wr_at_ack);
    @(posedge clk_i);
    #1;
    pix_stb_i = 1'b1;
    pix_set_i = s;
    pix_x_i   = 16'(x);
    pix_y_i   = 16'(y);
    flush_i   = fl;
    lat       = -1;
    wr_at_ack = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_i);
      #1;
      if (n == 1) begin
        pix_stb_i = 1'b0;
        flush_i   = 1'b0;
      end
      if (clip_ack_o) begin
        lat       = n;
        wr_at_ack = wq.size();
        break;
      end
    end
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got none expected clip_ack_o");
    end
  endtask

  task automatic flush_pulse();
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    repeat (6) @(posedge clk_i);
    #1;
  endtask

  vec_t vt[10];

  initial begin
    int lat, wa, nw, a0;
    logic [127:0] d;

    vt[0] = '{"clip_x1",  0,0,10,480, 32'h1000, 10,0,  1'b1, 1'b0,
              32'h0,     16'h0,    0, 16'h0};
    vt[1] = '{"edge_x",   0,0,10,480, 32'h1000, 9,0,   1'b1, 1'b1,
              32'h1010,  16'h000C, 1, 16'hF800};
    vt[2] = '{"clear_px", 0,0,640,480, 32'h1000, 2,0,  1'b0, BK,
              32'h1000,  16'h0030, 2, 16'h001F};
    vt[3] = '{"last_row", 0,0,640,480, 32'h1000, 5,479, 1'b1, 1'b1,
              32'h96B00, 16'h0C00, 5, 16'hF800};
    vt[4] = '{"clip_y1",  0,0,640,480, 32'h1000, 5,480, 1'b1, 1'b0,
              32'h0,     16'h0,    0, 16'h0};
    vt[5] = '{"base_lsb", 0,0,640,480, 32'h2007, 1,0,  1'b1, 1'b1,
              32'h2000,  16'h000C, 1, 16'hF800};
    vt[6] = '{"clip_x0",  4,0,640,480, 32'h1000, 3,0,  1'b1, 1'b0,
              32'h0,     16'h0,    0, 16'h0};
    vt[7] = '{"clip_y0",  0,2,640,480, 32'h1000, 0,1,  1'b1, 1'b0,
              32'h0,     16'h0,    0, 16'h0};
    vt[8] = '{"corner",   4,2,640,480, 32'h1000, 4,2,  1'b1, 1'b1,
              32'h1A00,  16'h0300, 4, 16'hF800};
    vt[9] = '{"lane7",    0,0,640,480, 32'h1000, 7,0,  1'b1, 1'b1,
              32'h1000,  16'hC000, 7, 16'hF800};

    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_ack", 128'(clip_ack_o), 128'(0));
    chk("rst_req", 128'(wr.write_request_o), 128'(0));
    chk("rst_adr", 128'(wr.write_adr_o), 128'(0));
    chk("rst_sel", 128'(wr.write_sel_o), 128'(0));
    chk("rst_dat", wr.write_dat_o, 128'(0));
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);

    // eight foreground pixels coalesce into one full word
    a0 = ack_cnt;
    for (int i = 0; i < 8; i++) begin
      plot(i, 0, 1'b1, 1'b0, lat, wa);
      chk($sformatf("row_lat%0d", i), 128'(lat), 128'(3));
    end
    chk("row_nowr", 128'(wq.size()), 128'(0));
    flush_pulse();
    chk("row_acks", 128'(ack_cnt - a0), 128'(8));
    chk_write("row", 32'h1000, 16'hFFFF, {8{16'hF800}});
    chk("row_single", 128'(wq.size()), 128'(0));

    // single pixel vectors, each followed by a flush
    foreach (vt[i]) begin
      clip_x0_i     = 16'(vt[i].x0);
      clip_y0_i     = 16'(vt[i].y0);
      clip_x1_i     = 16'(vt[i].x1);
      clip_y1_i     = 16'(vt[i].y1);
      target_base_i = vt[i].base;
      plot(vt[i].x, vt[i].y, vt[i].s, 1'b0, lat, wa);
      chk({vt[i].name, "_lat"}, 128'(lat), 128'(3));
      flush_pulse();
      nw = wq.size();
      chk({vt[i].name, "_nwr"}, 128'(nw), 128'(vt[i].exp_wr));
      if (vt[i].exp_wr && nw > 0) begin
        d = 128'(vt[i].col) << (vt[i].lane * 16);
        chk_write(vt[i].name, vt[i].adr, vt[i].sel, d);
      end
      wq.delete();
    end
    clip_x0_i = '0;
    clip_y0_i = '0;
    clip_x1_i = 16'd640;
    clip_y1_i = 16'd480;
    target_base_i = 32'h1000;

    // word change forces a write before the second ack
    plot(3, 1, 1'b1, 1'b0, lat, wa);
    chk("evict_lat1", 128'(lat), 128'(3));
    plot(8, 1, 1'b1, 1'b0, lat, wa);
    chk("evict_lat2", 128'(lat), 128'(5));
    chk("evict_before_ack", 128'(wa), 128'(1));
    chk_write("evict", 32'h1500, 16'h00C0, 128'(16'hF800) << 48);
    flush_pulse();
    chk_write("evict_tail", 32'h1510, 16'h0003, 128'(16'hF800));

    // repeated lane keeps the latest colour; clipped pixel leaves buffer
    plot(0, 0, 1'b1, 1'b0, lat, wa);
    fg_color_i = 16'h07E0;
    plot(0, 0, 1'b1, 1'b0, lat, wa);
    clip_x1_i = 16'd10;
    plot(10, 0, 1'b1, 1'b0, lat, wa);
    chk("clipbuf_lat", 128'(lat), 128'(3));
    chk("clipbuf_noreq", 128'(wq.size()), 128'(0));
    clip_x1_i = 16'd640;
    flush_pulse();
    chk_write("relane", 32'h1000, 16'h0003, 128'(16'h07E0));
    fg_color_i = 16'hF800;

    // empty-buffer flush does nothing
    flush_pulse();
    chk("empty_flush", 128'(wq.size()), 128'(0));

    // slow acknowledge: request and word held for five cycles
    plot(1, 0, 1'b1, 1'b0, lat, wa);
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("slow_req%0d", c), 128'(wr.write_request_o), 128'(1));
      chk($sformatf("slow_adr%0d", c), 128'(wr.write_adr_o),
          128'(32'h1000));
      chk($sformatf("slow_sel%0d", c), 128'(wr.write_sel_o),
          128'(16'h000C));
      chk($sformatf("slow_dat%0d", c), wr.write_dat_o,
          128'(16'hF800) << 16);
      if (c < 4) begin
        @(posedge clk_i);
        #1;
      end
    end
    man_ack = 1'b1;
    @(posedge clk_i);
    #1;
    man_ack = 1'b0;
    chk("slow_drop", 128'(wr.write_request_o), 128'(0));
    repeat (2) @(posedge clk_i);
    #1;
    chk("slow_empty", 128'(wr.write_request_o), 128'(0));
    auto_ack = 1'b1;
    repeat (2) @(posedge clk_i);

    // flush coincident with strobe runs after that pixel's ack
    plot(0, 0, 1'b1, 1'b1, lat, wa);
    chk("coinc_lat", 128'(lat), 128'(3));
    chk("coinc_wr_after", 128'(wa), 128'(0));
    repeat (6) @(posedge clk_i);
    #1;
    chk_write("coinc", 32'h1000, 16'h0003, 128'(16'hF800));

    // reset in the middle of a write drops it
    plot(4, 0, 1'b1, 1'b0, lat, wa);
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    @(posedge clk_i);
    #1;
    flush_i = 1'b1;
    @(posedge clk_i);
    #1;
    flush_i = 1'b0;
    @(posedge clk_i);
    #1;
    chk("rstw_pre", 128'(wr.write_request_o), 128'(1));
    #2;
    rst_i = 1'b0;
    #1;
    chk("rstw_drop", 128'(wr.write_request_o), 128'(0));
    chk("rstw_sel", 128'(wr.write_sel_o), 128'(0));
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    auto_ack = 1'b1;
    flush_pulse();
    chk("rstw_noflush", 128'(wq.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
